// File: rtl/data_memory_reader.sv
// Strided read sweep over the data-memory stack segment.
// Words stream out on valid/ready with a running checksum.
module data_memory_reader #(
  parameter logic [31:0] ADDR_LOWER_LIMIT = 32'h7FFF0000,
  parameter logic [31:0] ADDR_UPPER_LIMIT = 32'h7FFFFFFC,
  parameter int          COUNT_WIDTH      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [31:0]            base_addr,
  input  logic [COUNT_WIDTH-1:0] word_count,
  input  logic [15:0]            stride,
  output logic                   mem_write,
  output logic [31:0]            mem_address,
  output logic [31:0]            mem_write_data,
  input  logic [31:0]            mem_read_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_data,
  output logic [31:0]            out_addr,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [31:0]            checksum,
  output logic [COUNT_WIDTH-1:0] words_read
);

  typedef enum logic [2:0] {
    IDLE, CHECK, READ, HOLD, DONE
  } state_t;

  state_t                 state;
  state_t                 state_nx;
  logic [31:0]            cur_addr;
  logic [COUNT_WIDTH-1:0] remaining;
  logic [15:0]            stride_q;
  logic                   ovf;
  logic                   addr_bad;
  logic                   hs;
  logic                   last_word;
  logic [32:0]            next_addr;

  assign addr_bad  = (cur_addr[1:0] != 2'b00)
                   || (cur_addr < ADDR_LOWER_LIMIT)
                   || (cur_addr > ADDR_UPPER_LIMIT)
                   || ovf;
  assign hs        = out_valid && out_ready;
  assign last_word = (remaining == COUNT_WIDTH'(1));
  // Carry out of the 33-bit add flags a wrap past 2^32.
  assign next_addr = {1'b0, cur_addr} + {17'd0, stride_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start)
          state_nx = (word_count != '0) ? CHECK : DONE;
      end
      CHECK:   state_nx = addr_bad ? DONE : READ;
      READ:    state_nx = HOLD;
      HOLD: begin
        if (hs) state_nx = last_word ? DONE : CHECK;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    mem_write      = 1'b0;
    mem_write_data = 32'd0;
    busy           = (state != IDLE);
    done           = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_addr    <= '0;
      remaining   <= '0;
      stride_q    <= '0;
      ovf         <= 1'b0;
      mem_address <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_addr    <= '0;
      out_last    <= 1'b0;
      error       <= 1'b0;
      checksum    <= '0;
      words_read  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            cur_addr   <= base_addr;
            remaining  <= word_count;
            stride_q   <= stride;
            ovf        <= 1'b0;
            error      <= 1'b0;
            checksum   <= '0;
            words_read <= '0;
          end
        end
        CHECK: begin
          if (addr_bad) error       <= 1'b1;
          else          mem_address <= cur_addr;
        end
        READ: begin
          out_data  <= mem_read_data;
          out_addr  <= cur_addr;
          out_last  <= last_word;
          out_valid <= 1'b1;
        end
        HOLD: begin
          if (hs) begin
            out_valid  <= 1'b0;
            checksum   <= checksum + out_data;
            words_read <= words_read + COUNT_WIDTH'(1);
            remaining  <= remaining - COUNT_WIDTH'(1);
            cur_addr   <= next_addr[31:0];
            if (next_addr[32]) ovf <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_reader.sv
// Bench for data_memory_reader: table vectors, corner sequences
// and randomized sweeps against a queue-based reference model.
module tb_data_memory_reader;

  localparam longint LO = 64'h7FFF0000;
  localparam longint HI = 64'h7FFFFFFC;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] word_count;
  logic [15:0] stride;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [31:0] out_addr;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] checksum;
  logic [15:0] words_read;

  logic [31:0] salt = 32'd0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ salt;
  endfunction

  assign mem_read_data = memf(mem_address);

  data_memory_reader dut (
    .clk(clk), .rst(rst), .start(start),
    .base_addr(base_addr), .word_count(word_count),
    .stride(stride), .mem_write(mem_write),
    .mem_address(mem_address),
    .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr),
    .out_last(out_last), .busy(busy), .done(done),
    .error(error), .checksum(checksum),
    .words_read(words_read)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] base;
    logic [15:0] count;
    logic [15:0] strd;
    int          mode;
    bit          inject;
    logic        ex_err;
    logic [15:0] ex_words;
    logic [31:0] ex_cks;
  } vec_t;

  // mode 0: ready high, 1: random ready, 2: 5-cycle stall
  task automatic run_sweep(input string nm,
                           input logic [31:0] b,
                           input logic [15:0] n,
                           input logic [15:0] s,
                           input int mode,
                           input bit inject,
                           input bit use_exp,
                           input logic ex_err,
                           input logic [15:0] ex_words,
                           input logic [31:0] ex_cks);
    logic [31:0] qa[$];
    logic [31:0] qd[$];
    longint a;
    bit merr;
    logic [31:0] msum;
    logic [31:0] run_sum;
    int idx;
    int first;
    int stall;
    bit seen_done;
    bit bad_addr;
    a = longint'(b);
    merr = 1'b0;
    msum = 32'd0;
    for (int k = 0; k < int'(n); k++) begin
      if (a[1:0] != 2'b00 || a < LO || a > HI) begin
        merr = 1'b1;
        break;
      end
      qa.push_back(a[31:0]);
      qd.push_back(memf(a[31:0]));
      msum = msum + memf(a[31:0]);
      a = a + longint'(s);
    end
    if (!use_exp) begin
      ex_err = merr;
      ex_words = 16'(qa.size());
      ex_cks = msum;
    end
    @(negedge clk);
    base_addr = b;
    word_count = n;
    stride = s;
    start = 1'b1;
    out_ready = (mode != 2);
    @(negedge clk);
    start = 1'b0;
    idx = 0;
    run_sum = 32'd0;
    first = -1;
    stall = 0;
    seen_done = 1'b0;
    bad_addr = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (!(mem_address == 32'd0 ||
            (longint'(mem_address) >= LO &&
             longint'(mem_address) <= HI)))
        bad_addr = 1'b1;
      chk({nm, ".cks_run"}, checksum, run_sum);
      chk({nm, ".words_run"}, 32'(words_read), 32'(idx));
      if (out_valid) begin
        if (first < 0) begin
          first = cyc;
          if (mode == 2) stall = 5;
        end
        if (idx >= qa.size()) begin
          chk({nm, ".extra_beat"}, 32'(idx), 32'(qa.size()));
        end else begin
          chk({nm, ".addr"}, out_addr, qa[idx]);
          chk({nm, ".data"}, out_data, qd[idx]);
          chk({nm, ".last"}, 32'(out_last),
              32'(idx == int'(n) - 1));
          chk({nm, ".mem_addr"}, mem_address, qa[idx]);
        end
      end
      if (done) begin
        seen_done = 1'b1;
        chk({nm, ".error"}, 32'(error), 32'(ex_err));
        chk({nm, ".words"}, 32'(words_read), 32'(ex_words));
        chk({nm, ".cks"}, checksum, ex_cks);
      end
      if (inject && cyc == 3) begin
        start = 1'b1;
        base_addr = 32'h7FFF0002;
        word_count = 16'd9;
        stride = 16'd1;
      end else begin
        start = 1'b0;
      end
      if (mode == 1) out_ready = 1'($urandom_range(0, 1));
      else if (mode == 2) begin
        if (stall > 0) begin
          out_ready = 1'b0;
          stall--;
        end else begin
          out_ready = 1'b1;
        end
      end else out_ready = 1'b1;
      if (out_valid && out_ready && idx < qa.size()) begin
        run_sum = run_sum + qd[idx];
        idx++;
      end
      @(negedge clk);
      if (seen_done) break;
    end
    chk({nm, ".done_seen"}, 32'(seen_done), 32'd1);
    chk({nm, ".done_pulse"}, 32'(done), 32'd0);
    chk({nm, ".busy_after"}, 32'(busy), 32'd0);
    chk({nm, ".beats"}, 32'(idx), 32'(qa.size()));
    chk({nm, ".mem_range"}, 32'(bad_addr), 32'd0);
    if (mode == 0 && qa.size() > 0)
      chk({nm, ".latency"}, 32'(first), 32'd2);
  endtask

  vec_t vt[$];

  initial begin
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    word_count = '0;
    stride = '0;
    out_ready = 1'b0;
    vt.push_back('{"normal", 32'h7FFF0000, 16'd4, 16'h0010,
                   0, 1'b0, 1'b0, 16'd4, 32'hFFFC0060});
    vt.push_back('{"upper", 32'h7FFFFFF0, 16'd8, 16'h0010,
                   0, 1'b0, 1'b1, 16'd1, 32'h7FFFFFF0});
    vt.push_back('{"misalign", 32'h7FFF0002, 16'd1, 16'h0004,
                   0, 1'b0, 1'b1, 16'd0, 32'h0});
    vt.push_back('{"below", 32'h7FFEFFFC, 16'd2, 16'h0004,
                   0, 1'b0, 1'b1, 16'd0, 32'h0});
    vt.push_back('{"stall", 32'h7FFF0100, 16'd2, 16'h0004,
                   2, 1'b0, 1'b0, 16'd2, 32'hFFFE0204});
    vt.push_back('{"count0", 32'h7FFF0000, 16'd0, 16'h0004,
                   0, 1'b0, 1'b0, 16'd0, 32'h0});
    vt.push_back('{"stride0", 32'h7FFFFFFC, 16'd3, 16'h0000,
                   0, 1'b0, 1'b0, 16'd3, 32'h7FFFFFF4});
    vt.push_back('{"odd_stride", 32'h7FFF0000, 16'd3, 16'h0002,
                   0, 1'b0, 1'b1, 16'd1, 32'h7FFF0000});
    vt.push_back('{"restart", 32'h7FFF0040, 16'd3, 16'h0004,
                   0, 1'b1, 1'b0, 16'd3, 32'h7FFD00CC});

    #1;
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.mem_addr", mem_address, 32'd0);
    chk("rst.cks", checksum, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vt.size(); i++)
      run_sweep(vt[i].name, vt[i].base, vt[i].count,
                vt[i].strd, vt[i].mode, vt[i].inject, 1'b1,
                vt[i].ex_err, vt[i].ex_words, vt[i].ex_cks);

    // Asynchronous reset during HOLD of the second word.
    begin
      bit hit;
      bit dseen;
      hit = 1'b0;
      dseen = 1'b0;
      @(negedge clk);
      base_addr = 32'h7FFF0000;
      word_count = 16'd4;
      stride = 16'h0010;
      out_ready = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 50; c++) begin
        if (out_valid && words_read == 16'd1) begin
          hit = 1'b1;
          out_ready = 1'b0;
          break;
        end
        @(negedge clk);
      end
      chk("arst.reached_hold2", 32'(hit), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("arst.valid", 32'(out_valid), 32'd0);
      chk("arst.data", out_data, 32'd0);
      chk("arst.addr", out_addr, 32'd0);
      chk("arst.mem_addr", mem_address, 32'd0);
      chk("arst.busy", 32'(busy), 32'd0);
      chk("arst.cks", checksum, 32'd0);
      chk("arst.words", 32'(words_read), 32'd0);
      chk("arst.misc", {27'd0, out_last, done, error,
                        mem_write, 1'b0} | mem_write_data,
          32'd0);
      repeat (2) begin
        @(negedge clk);
        if (done) dseen = 1'b1;
      end
      rst = 1'b0;
      chk("arst.no_done", 32'(dseen), 32'd0);
      run_sweep("after_rst", 32'h7FFF0000, 16'd4, 16'h0010,
                0, 1'b0, 1'b1, 1'b0, 16'd4, 32'hFFFC0060);
    end

    for (int r = 0; r < 40; r++) begin
      logic [31:0] b;
      logic [15:0] s;
      logic [15:0] n;
      salt = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'h7FFF0000 + {16'd0, 16'($urandom) & 16'hFFFC};
        1: b = 32'h7FFFFFFC - 32'($urandom_range(0, 64)) * 4;
        2: b = 32'h7FFF0000 + 32'($urandom_range(0, 64)) * 4
               + 32'($urandom_range(1, 3));
        default: b = 32'h7FFF0000 - 32'($urandom_range(1, 8)) * 4;
      endcase
      case ($urandom_range(0, 4))
        0: s = 16'h0000;
        1: s = 16'h0004;
        2: s = 16'hFFFC;
        3: s = 16'($urandom);
        default: s = 16'h0010;
      endcase
      n = 16'($urandom_range(0, 6));
      run_sweep("rand", b, n, s, 1, 1'b0, 1'b0,
                1'b0, 16'd0, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
